// File: rtl/balun_pkg.sv
// Shared types and helpers for the balun leg combiner.
// Holds the default sample width, skew FSM states and the common-mode helper.
package balun_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        DRIFT = 2'd1,
        FAULT = 2'd2
    } skew_state_t;

    // Callers sign-extend each leg to 32 bits before calling.
    // The sum of two legs of up to 30 bits cannot overflow at this width.
    // The arithmetic shift gives the floor of (a + b) / 2.
    function automatic logic signed [31:0] sext_half(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        return (a + b) >>> 1;
    endfunction

endpackage

// File: rtl/leg_fifo.sv
// Per-leg alignment FIFO. Pointers carry one extra wrap bit.
// Ports: clr (sync clear), push/din, pop/dout, full, empty, count.
module leg_fifo
    import balun_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/balun_leg_combiner.sv
// Re-aligns the P and N leg streams and emits diff / common-mode pairs.
// Ports: p_*/n_* leg handshakes, out_* pair stream, skew_err, pair_cnt.
module balun_leg_combiner
    import balun_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int DEPTH    = 4,
    parameter int SKEW_LIM = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          p_valid,
    output logic          p_ready,
    input  logic [W-1:0]  p_data,
    input  logic          n_valid,
    output logic          n_ready,
    input  logic [W-1:0]  n_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    out_diff,
    output logic [W-1:0]  out_cm,
    output logic          skew_err,
    output logic [15:0]   pair_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  p_dout;
    logic [W-1:0]  n_dout;
    logic          p_full;
    logic          n_full;
    logic          p_empty;
    logic          n_empty;
    logic [CW-1:0] p_cnt;
    logic [CW-1:0] n_cnt;
    logic          p_push;
    logic          n_push;
    logic          pair_pop;
    logic          out_fire;

    skew_state_t   state;
    logic [7:0]    dc;

    assign p_ready = ~p_full;
    assign n_ready = ~n_full;

    // Flush drops anything presented in the same cycle.
    assign p_push = p_valid & p_ready & ~flush;
    assign n_push = n_valid & n_ready & ~flush;

    assign out_fire = out_valid & out_ready;

    // Both legs always leave together; the output slot must be free
    // or emptying this cycle.
    assign pair_pop = ~p_empty & ~n_empty
                    & (~out_valid | out_ready) & ~flush;

    leg_fifo #(.W(W), .DEPTH(DEPTH)) u_p_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (p_push),
        .pop   (pair_pop),
        .din   (p_data),
        .dout  (p_dout),
        .full  (p_full),
        .empty (p_empty),
        .count (p_cnt)
    );

    leg_fifo #(.W(W), .DEPTH(DEPTH)) u_n_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (n_push),
        .pop   (pair_pop),
        .din   (n_data),
        .dout  (n_dout),
        .full  (n_full),
        .empty (n_empty),
        .count (n_cnt)
    );

    logic signed [W:0]  p_x;
    logic signed [W:0]  n_x;
    logic signed [W:0]  diff;
    logic        [W-1:0] cm;

    assign p_x  = {p_dout[W-1], p_dout};
    assign n_x  = {n_dout[W-1], n_dout};
    assign diff = p_x - n_x;
    // The halved sum always fits in W bits, so truncation is exact.
    assign cm   = W'(sext_half(32'(p_x), 32'(n_x)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_diff  <= '0;
            out_cm    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pair_pop) begin
            out_valid <= 1'b1;
            out_diff  <= diff;
            out_cm    <= cm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt <= '0;
        end else if (!flush && out_fire) begin
            pair_cnt <= pair_cnt + 16'd1;
        end
    end

    // dc counts cycles spent in DRIFT and saturates at SKEW_LIM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
            dc    <= '0;
        end else if (flush) begin
            state <= SYNC;
            dc    <= '0;
        end else begin
            unique case (state)
                SYNC: begin
                    if (p_cnt != n_cnt) begin
                        state <= DRIFT;
                        dc    <= 8'd1;
                    end
                end
                DRIFT: begin
                    if (p_cnt == n_cnt) begin
                        state <= SYNC;
                        dc    <= '0;
                    end else if (dc >= 8'(SKEW_LIM)
                                 && (p_full || n_full)) begin
                        state <= FAULT;
                    end else if (dc < 8'(SKEW_LIM)) begin
                        dc <= dc + 8'd1;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= SYNC;
                    dc    <= '0;
                end
            endcase
        end
    end

    assign skew_err = (state == FAULT);

endmodule

// File: tb/tb_balun_leg_combiner.sv
// Directed self-checking bench for balun_leg_combiner.
// One task per scenario, called in order from a single initial block.
module tb_balun_leg_combiner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        p_valid;
    logic        p_ready;
    logic [15:0] p_data;
    logic        n_valid;
    logic        n_ready;
    logic [15:0] n_data;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_diff;
    logic [15:0] out_cm;
    logic        skew_err;
    logic [15:0] pair_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] qd[$];
    logic [15:0] qc[$];

    always #5 clk = ~clk;

    balun_leg_combiner #(.W(16), .DEPTH(4), .SKEW_LIM(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .p_data    (p_data),
        .n_valid   (n_valid),
        .n_ready   (n_ready),
        .n_data    (n_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_cm    (out_cm),
        .skew_err  (skew_err),
        .pair_cnt  (pair_cnt)
    );

    // Record every delivered pair mid-cycle, when inputs are stable.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            qd.push_back(out_diff);
            qc.push_back(out_cm);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_valid = 1'b0;
        n_valid = 1'b0;
        p_data  = '0;
        n_data  = '0;
        flush   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({out_valid, out_diff, out_cm, skew_err} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got v=%0b d=%0h c=%0h s=%0b required all 0",
                     out_valid, out_diff, out_cm, skew_err);
        end
        n_cmp++;
        if (pair_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d required 0", pair_cnt);
        end
        n_cmp++;
        if ({p_ready, n_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_ready: got %b required 11", {p_ready, n_ready});
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_matched();
        logic [15:0] pv[3];
        logic [15:0] nv[3];
        logic [16:0] ed[3];
        logic [15:0] ec[3];
        pv = '{16'd100, 16'd200, 16'd300};
        nv = '{16'd40, 16'hFFCE, 16'd300};
        ed = '{17'd60, 17'd250, 17'd0};
        ec = '{16'd70, 16'd75, 16'd300};
        qd.delete();
        qc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_valid = 1'b1;
            n_valid = 1'b1;
            p_data  = pv[i];
            n_data  = nv[i];
            step();
        end
        idle_inputs();
        repeat (5) step();
        n_cmp++;
        if (qd.size() !== 3) begin
            n_bad++;
            $display("FAIL matched_count: got %0d required 3", qd.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < qd.size()) begin
                n_cmp++;
                if (qd[i] !== ed[i] || qc[i] !== ec[i]) begin
                    n_bad++;
                    $display("FAIL matched_pair%0d: got (%0h,%0h) required (%0h,%0h)",
                             i, qd[i], qc[i], ed[i], ec[i]);
                end
            end
        end
        n_cmp++;
        if (pair_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL matched_cnt: got %0d required 3", pair_cnt);
        end
    endtask

    task automatic test_extremes();
        qd.delete();
        qc.delete();
        out_ready = 1'b1;
        p_valid = 1'b1;
        n_valid = 1'b1;
        p_data  = 16'h7FFF;
        n_data  = 16'h8000;
        step();
        p_data  = 16'hFFFD;
        n_data  = 16'h0000;
        step();
        idle_inputs();
        repeat (4) step();
        n_cmp++;
        if (qd.size() !== 2) begin
            n_bad++;
            $display("FAIL extremes_count: got %0d required 2", qd.size());
        end else begin
            n_cmp++;
            if (qd[0] !== 17'h0FFFF || qc[0] !== 16'hFFFF) begin
                n_bad++;
                $display("FAIL extremes_max: got (%0h,%0h) required (ffff,ffff)",
                         qd[0], qc[0]);
            end
            n_cmp++;
            if (qd[1] !== 17'h1FFFD || qc[1] !== 16'hFFFE) begin
                n_bad++;
                $display("FAIL extremes_floor: got (%0h,%0h) required (1fffd,fffe)",
                         qd[1], qc[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] ed[5];
        logic [15:0] ec[5];
        ed = '{17'd1000, 17'd999, 17'd998, 17'd997, 17'd996};
        ec = '{16'd500, 16'd501, 16'd503, 16'd504, 16'd506};
        qd.delete();
        qc.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            p_valid = 1'b1;
            n_valid = 1'b1;
            p_data  = 16'(1000 + i);
            n_data  = 16'(2 * i);
            step();
            if (i == 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_diff !== 17'd1000) begin
                    n_bad++;
                    $display("FAIL bp_hold_early: got v=%0b d=%0d required v=1 d=1000",
                             out_valid, out_diff);
                end
            end
        end
        n_cmp++;
        if ({p_ready, n_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_ready: got %b required 00", {p_ready, n_ready});
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_diff !== 17'd1000 || out_cm !== 16'd500) begin
            n_bad++;
            $display("FAIL bp_hold: got v=%0b d=%0d c=%0d required v=1 d=1000 c=500",
                     out_valid, out_diff, out_cm);
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (8) step();
        n_cmp++;
        if (qd.size() !== 5) begin
            n_bad++;
            $display("FAIL bp_count: got %0d required 5", qd.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < qd.size()) begin
                n_cmp++;
                if (qd[i] !== ed[i] || qc[i] !== ec[i]) begin
                    n_bad++;
                    $display("FAIL bp_pair%0d: got (%0d,%0d) required (%0d,%0d)",
                             i, qd[i], qc[i], ed[i], ec[i]);
                end
            end
        end
        n_cmp++;
        if (pair_cnt !== 16'd10) begin
            n_bad++;
            $display("FAIL bp_cnt: got %0d required 10", pair_cnt);
        end
    endtask

    task automatic test_skew();
        qd.delete();
        qc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p_valid = 1'b1;
            p_data  = 16'(5 + i);
            step();
        end
        n_cmp++;
        if (skew_err !== 1'b0 || p_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL skew_early: got err=%0b rdy=%0b required err=0 rdy=0",
                     skew_err, p_ready);
        end
        idle_inputs();
        repeat (8) step();
        n_cmp++;
        if (skew_err !== 1'b1) begin
            n_bad++;
            $display("FAIL skew_rise: got %0b required 1", skew_err);
        end
        for (int i = 0; i < 4; i++) begin
            n_valid = 1'b1;
            n_data  = 16'(1 + i);
            step();
        end
        idle_inputs();
        repeat (6) step();
        n_cmp++;
        if (skew_err !== 1'b1 || qd.size() !== 4) begin
            n_bad++;
            $display("FAIL skew_sticky: got err=%0b pairs=%0d required err=1 pairs=4",
                     skew_err, qd.size());
        end
        if (qd.size() == 4) begin
            n_cmp++;
            if (qd[3] !== 17'd4 || qc[3] !== 16'd6) begin
                n_bad++;
                $display("FAIL skew_pair: got (%0d,%0d) required (4,6)", qd[3], qc[3]);
            end
        end
        flush   = 1'b1;
        p_valid = 1'b1;
        p_data  = 16'd77;
        n_valid = 1'b1;
        n_data  = 16'd7;
        step();
        idle_inputs();
        n_cmp++;
        if (skew_err !== 1'b0 || out_valid !== 1'b0 || {p_ready, n_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL flush_clear: got err=%0b v=%0b rdy=%b required 0 0 11",
                     skew_err, out_valid, {p_ready, n_ready});
        end
        repeat (3) step();
        n_cmp++;
        if (out_valid !== 1'b0 || pair_cnt !== 16'd14) begin
            n_bad++;
            $display("FAIL flush_drop: got v=%0b cnt=%0d required v=0 cnt=14",
                     out_valid, pair_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit rdy_ok = 1'b1;
        qd.delete();
        qc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p_valid = 1'b1;
            n_valid = 1'b1;
            p_data  = 16'(10 * i);
            n_data  = 16'(i);
            if (!p_ready || !n_ready) rdy_ok = 1'b0;
            step();
        end
        idle_inputs();
        step();
        @(negedge clk);
        #1;
        n_cmp++;
        if (qd.size() !== 8 || !rdy_ok) begin
            n_bad++;
            $display("FAIL b2b_rate: got pairs=%0d ready_ok=%0b required 8 1",
                     qd.size(), rdy_ok);
        end
        if (qd.size() == 8) begin
            n_cmp++;
            if (qd[7] !== 17'd63 || qc[7] !== 16'd38) begin
                n_bad++;
                $display("FAIL b2b_last: got (%0d,%0d) required (63,38)", qd[7], qc[7]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p_valid = 1'b1;
            n_valid = 1'b1;
            p_data  = 16'(10 + i);
            n_data  = 16'(i);
            step();
        end
        idle_inputs();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_pending: got v=%0b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_diff, out_cm, pair_cnt} !== 50'd0) begin
            n_bad++;
            $display("FAIL rmid_clear: got v=%0b d=%0h c=%0h cnt=%0d required 0",
                     out_valid, out_diff, out_cm, pair_cnt);
        end
        n_cmp++;
        if ({p_ready, n_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL rmid_ready: got %b required 11", {p_ready, n_ready});
        end
        #2 rst_n = 1'b1;
        step();
        p_valid = 1'b1;
        n_valid = 1'b1;
        p_data  = 16'd50;
        n_data  = 16'd20;
        step();
        idle_inputs();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_lat1: got v=%0b required 0", out_valid);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || out_diff !== 17'd30 || out_cm !== 16'd35) begin
            n_bad++;
            $display("FAIL rmid_lat2: got v=%0b d=%0d c=%0d required 1 30 35",
                     out_valid, out_diff, out_cm);
        end
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (pair_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL rmid_cnt: got %0d required 1", pair_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_matched();
        test_extremes();
        test_backpressure();
        test_skew();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
